fpu_mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-precision FPU multiplier among NREQ requesters.
- Each requester presents an operand pair with a strobe/ack handshake and receives its product on a shared result bus, with a one-hot response strobe.
- Talks to the multiplier over its serial port protocol: a first, then b, then z.
- Only one multiply is in flight at a time.

---
 rtl/fpu_mul_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_arbiter.sv
// fpu_mul_arbiter: round-robin arbiter/sequencer sharing one serial-port FPU
// multiplier among NREQ requesters. One multiply in flight at a time; operands
// and product pass through bit-exact.
// Optional: define FPU_ARB_TIMEOUT_EN to abort a WAIT_Z that exceeds TIMEOUT
// cycles (product 32'hFFC00000, resp_err=1, one-cycle multiplier reset pulse).
module fpu_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_stb,
  output logic [NREQ-1:0]      req_ack,
  output logic [31:0]          resp_z,
  output logic                 resp_err,
  output logic [NREQ-1:0]      resp_stb,
  input  logic [NREQ-1:0]      resp_ack,
  output logic [31:0]          mul_a,
  output logic                 mul_a_stb,
  input  logic                 mul_a_ack,
  output logic [31:0]          mul_b,
  output logic                 mul_b_stb,
  input  logic                 mul_b_ack,
  input  logic [31:0]          mul_z,
  input  logic                 mul_z_stb,
  output logic                 mul_z_ack,
  output logic                 mul_rst
);

  localparam int unsigned IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fpu_mul_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fpu_mul_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  gid_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [NREQ-1:0] req_ack_q;
  logic [NREQ-1:0] resp_stb_q;
  logic [31:0]     resp_z_q;
  logic [31:0]     mul_a_q;
  logic [31:0]     mul_b_q;
  logic            mul_a_stb_q;
  logic            mul_b_stb_q;
  logic            mul_z_ack_q;

  logic [IDW-1:0]  grant_d;
  logic            grant_vld_d;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tmo_cnt_q;
  logic            resp_err_q;
  logic            abort_q;
`endif

  // Round-robin pick: the modulo search from rr_ptr+1 is split into two
  // linear passes (indices above rr_ptr, then wrap to indices up to rr_ptr).
  always_comb begin
    grant_d     = '0;
    grant_vld_d = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld_d && (i > 32'(rr_ptr_q)) && req_stb[i]) begin
        grant_vld_d = 1'b1;
        grant_d     = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld_d && (i <= 32'(rr_ptr_q)) && req_stb[i]) begin
        grant_vld_d = 1'b1;
        grant_d     = IDW'(i);
      end
    end
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gid_q       <= '0;
      rr_ptr_q    <= IDW'(NREQ - 1);
      req_ack_q   <= '0;
      resp_stb_q  <= '0;
      resp_z_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_a_stb_q <= 1'b0;
      mul_b_stb_q <= 1'b0;
      mul_z_ack_q <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      resp_err_q  <= 1'b0;
      abort_q     <= 1'b0;
`endif
    end else begin
      req_ack_q <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      abort_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            gid_q              <= grant_d;
            rr_ptr_q           <= grant_d;
            req_ack_q[grant_d] <= 1'b1;
            mul_a_q            <= req_a[32*grant_d +: 32];
            mul_b_q            <= req_b[32*grant_d +: 32];
            mul_a_stb_q        <= 1'b1;
            state_q            <= SEND_A;
          end
        end
        SEND_A: begin
          if (mul_a_stb_q && mul_a_ack) begin
            mul_a_stb_q <= 1'b0;
            mul_b_stb_q <= 1'b1;
            state_q     <= SEND_B;
          end
        end
        SEND_B: begin
          if (mul_b_stb_q && mul_b_ack) begin
            mul_b_stb_q <= 1'b0;
            mul_z_ack_q <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
            state_q     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (mul_z_stb && mul_z_ack_q) begin
            resp_z_q          <= mul_z;
            mul_z_ack_q       <= 1'b0;
            resp_stb_q[gid_q] <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
            resp_err_q        <= 1'b0;
`endif
            state_q           <= RESP;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            resp_z_q          <= 32'hFFC0_0000;
            resp_err_q        <= 1'b1;
            mul_z_ack_q       <= 1'b0;
            abort_q           <= 1'b1;
            resp_stb_q[gid_q] <= 1'b1;
            state_q           <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (|(resp_ack & resp_stb_q)) begin
            resp_stb_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack   = req_ack_q;
  assign resp_stb  = resp_stb_q;
  assign resp_z    = resp_z_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_a_stb = mul_a_stb_q;
  assign mul_b_stb = mul_b_stb_q;
  assign mul_z_ack = mul_z_ack_q;

`ifdef FPU_ARB_TIMEOUT_EN
  assign resp_err = resp_err_q;
  assign mul_rst  = rst | abort_q;
`else
  assign resp_err = 1'b0;
  assign mul_rst  = rst;
`endif

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed self-checking bench for fpu_mul_arbiter (NREQ=4, TIMEOUT=16).
// A stub multiplier returns hand-computed products from a small table.
module tb_fpu_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_stb, req_ack, resp_stb, resp_ack;
  logic [31:0]  resp_z, mul_a, mul_b, mul_z;
  logic         resp_err, mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack;
  logic         mul_z_stb, mul_z_ack, mul_rst;

  logic [3:0]   ack_en, sticky;
  logic         hang;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_mul_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_err(resp_err), .resp_stb(resp_stb), .resp_ack(resp_ack),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .mul_rst(mul_rst)
  );

  // Hand-computed IEEE-754 single products for the operand pairs used below.
  function automatic logic [31:0] fmul_tab(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000; // 2 * 3 = 6
      64'h3F800000_41200000: return 32'h41200000; // 1 * 10 = 10
      64'h3FC00000_3FC00000: return 32'h40100000; // 1.5 * 1.5 = 2.25
      64'h40800000_3F000000: return 32'h40000000; // 4 * 0.5 = 2
      64'h40A00000_40000000: return 32'h41200000; // 5 * 2 = 10
      default:               return 32'h7FC0DEAD;
    endcase
  endfunction

  // Stub multiplier: a, then b, two cycles of latency, then z.
  logic [1:0]  st = '0;
  logic [31:0] sa = '0, sb = '0;
  int          lat = 0;
  assign mul_a_ack = (st == 2'd0);
  assign mul_b_ack = (st == 2'd1);
  assign mul_z_stb = (st == 2'd3) && !hang;
  assign mul_z     = fmul_tab(sa, sb);

  always @(posedge clk) begin
    if (mul_rst) st <= 2'd0;
    else begin
      case (st)
        2'd0: if (mul_a_stb && mul_a_ack) begin sa <= mul_a; st <= 2'd1; end
        2'd1: if (mul_b_stb && mul_b_ack) begin sb <= mul_b; lat <= 2; st <= 2'd2; end
        2'd2: if (lat == 0) st <= 2'd3; else lat <= lat - 1;
        default: if (mul_z_stb && mul_z_ack) st <= 2'd0;
      endcase
    end
  end

  // Passive monitors: grants, responses, multiplier transfers, pulse counts.
  int          grant_log[$];
  logic [36:0] resp_log[$];   // {resp_stb, resp_err, resp_z}
  logic [31:0] xfer_log[$];
  int ack_cycles = 0, onehot_err = 0, mrst_cycles = 0, zack_cycles = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (req_ack != 4'b0) begin
        ack_cycles <= ack_cycles + 1;
        if ($countones(req_ack) != 1) onehot_err <= onehot_err + 1;
        for (int i = 0; i < 4; i++) if (req_ack[i]) grant_log.push_back(i);
      end
      if ($countones(resp_stb) > 1) onehot_err <= onehot_err + 1;
      if (|(resp_stb & resp_ack)) resp_log.push_back({resp_stb, resp_err, resp_z});
      if (mul_a_stb && mul_a_ack) xfer_log.push_back(mul_a);
      if (mul_b_stb && mul_b_ack) xfer_log.push_back(mul_b);
      if (mul_rst) mrst_cycles <= mrst_cycles + 1;
      if (mul_z_ack) zack_cycles <= zack_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of requester behaviour: drop acked strobes, ack offered results.
  task automatic tick();
    @(negedge clk);
    req_stb  = req_stb & ~(req_ack & ~sticky);
    resp_ack = resp_stb & ack_en;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_stb[i] = 1'b1;
  endtask

  task automatic wait_resp(input int n, input string tag);
    int budget = 0;
    while (resp_log.size() < n && budget < 2000) begin tick(); budget++; end
    check(tag, resp_log.size(), n);
  endtask

  task automatic wait_grant(input int n, input string tag);
    int budget = 0;
    while (grant_log.size() < n && budget < 2000) begin tick(); budget++; end
    check(tag, grant_log.size(), n);
  endtask

  task automatic check_resp(input int k, input int idx, input logic [31:0] z,
                            input logic err, input string tag);
    logic [36:0] e;
    logic [3:0]  m;
    e = (k < resp_log.size()) ? resp_log[k] : '0;
    m = 4'b0001 << idx;
    check({tag, "_stb"}, e[36:33], m);
    check({tag, "_err"}, e[32], err);
    check({tag, "_z"}, e[31:0], z);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ack"}, req_ack, 4'b0);
    check({tag, "_resp_stb"}, resp_stb, 4'b0);
    check({tag, "_resp_z"}, {resp_err, resp_z}, 33'h0);
    check({tag, "_mul_stbs"}, {mul_a_stb, mul_b_stb, mul_z_ack}, 3'b0);
    check({tag, "_mul_ab"}, {mul_a, mul_b}, 64'h0);
    check({tag, "_mul_rst"}, mul_rst, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, rb, ab, mb, zb, viol, budget;
    logic [31:0] exp_z [4];
    rst = 1'b1; req_a = '0; req_b = '0; req_stb = '0; resp_ack = '0;
    ack_en = 4'hF; sticky = '0; hang = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("reset_release_mul_rst", mul_rst, 1'b0);

    // All four request together: grants 0,1,2,3 from reset pointer.
    exp_z = '{32'h40C00000, 32'h41200000, 32'h40100000, 32'h40000000};
    gb = grant_log.size(); rb = resp_log.size();
    set_req(0, 32'h40000000, 32'h40400000);
    set_req(1, 32'h3F800000, 32'h41200000);
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    set_req(3, 32'h40800000, 32'h3F000000);
    wait_resp(rb + 4, "all4_done");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("all4_grant%0d", i), (gb + i < grant_log.size()) ? grant_log[gb + i] : -1, i);
      check_resp(rb + i, i, exp_z[i], 1'b0, $sformatf("all4_resp%0d", i));
    end

    // Single request: 1-cycle ack latency, a then b to the multiplier.
    gb = grant_log.size(); rb = resp_log.size(); ab = ack_cycles; mb = xfer_log.size();
    set_req(0, 32'h40000000, 32'h40400000);
    tick();
    check("single_ack_latency", req_ack, 4'b0001);
    wait_resp(rb + 1, "single_done");
    check("single_ack_pulse", ack_cycles - ab, 1);
    check("single_xfer_a", (mb < xfer_log.size()) ? xfer_log[mb] : '0, 32'h40000000);
    check("single_xfer_b", (mb + 1 < xfer_log.size()) ? xfer_log[mb + 1] : '0, 32'h40400000);
    check_resp(rb, 0, 32'h40C00000, 1'b0, "single");

    // Fairness: req1 continuous, req3 once -> 1,3,1.
    gb = grant_log.size(); rb = resp_log.size();
    sticky[1] = 1'b1;
    set_req(1, 32'h3F800000, 32'h41200000);
    wait_grant(gb + 1, "fair_first");
    set_req(3, 32'h40800000, 32'h3F000000);
    wait_grant(gb + 3, "fair_three");
    sticky[1] = 1'b0; req_stb[1] = 1'b0;
    wait_resp(rb + 3, "fair_done");
    repeat (5) tick();
    check("fair_grant_count", grant_log.size(), gb + 3);
    check("fair_order", {grant_log[gb], grant_log[gb + 1], grant_log[gb + 2]}, {32'd1, 32'd3, 32'd1});
    check_resp(rb + 1, 3, 32'h40000000, 1'b0, "fair_req3");
    check_resp(rb + 2, 1, 32'h41200000, 1'b0, "fair_req1");

    // Backpressure: result held 20 cycles, no new grant while pending.
    gb = grant_log.size(); rb = resp_log.size();
    ack_en[0] = 1'b0;
    set_req(0, 32'h40A00000, 32'h40000000);
    wait_grant(gb + 1, "bp_grant");
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    budget = 0;
    while (resp_stb !== 4'b0001 && budget < 200) begin tick(); budget++; end
    check("bp_resp_stb", resp_stb, 4'b0001);
    viol = 0;
    repeat (20) begin
      tick();
      if (resp_stb !== 4'b0001 || resp_z !== 32'h41200000) viol++;
      if (mul_a_stb !== 1'b0 || req_ack !== 4'b0) viol++;
    end
    check("bp_hold_violations", viol, 0);
    check("bp_no_new_grant", grant_log.size(), gb + 1);
    ack_en[0] = 1'b1;
    wait_resp(rb + 2, "bp_done");
    check_resp(rb, 0, 32'h41200000, 1'b0, "bp_req0");
    check_resp(rb + 1, 2, 32'h40100000, 1'b0, "bp_req2");

    // Reset while in WAIT_Z: no response, outputs back to reset values.
    hang = 1'b1;
    set_req(1, 32'h3F800000, 32'h41200000);
    budget = 0;
    while (mul_z_ack !== 1'b1 && budget < 200) begin tick(); budget++; end
    check("rst_reach_wait_z", mul_z_ack, 1'b1);
    repeat (3) tick();
    rb = resp_log.size();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0; hang = 1'b0;
    tick();
    check("midrst_mul_rst_release", mul_rst, 1'b0);
    check("midrst_no_resp", resp_log.size(), rb);
    set_req(1, 32'h3F800000, 32'h41200000);
    wait_resp(rb + 1, "midrst_next_done");
    check_resp(rb, 1, 32'h41200000, 1'b0, "midrst_next");

`ifdef FPU_ARB_TIMEOUT_EN
    // Timeout abort after 16 WAIT_Z cycles, then a normal transaction.
    rb = resp_log.size(); mb = mrst_cycles; zb = zack_cycles;
    hang = 1'b1;
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    wait_resp(rb + 1, "tmo_done");
    check_resp(rb, 2, 32'hFFC00000, 1'b1, "tmo");
    check("tmo_wait_cycles", zack_cycles - zb, 16);
    check("tmo_mul_rst_pulse", mrst_cycles - mb, 1);
    hang = 1'b0;
    set_req(3, 32'h40800000, 32'h3F000000);
    wait_resp(rb + 2, "tmo_next_done");
    check_resp(rb + 1, 3, 32'h40000000, 1'b0, "tmo_next");
`endif

    check("resp_onehot", onehot_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
